// File: rtl/ds_scoreboard_pkg.sv
// Shared constants for the decode-stage register scoreboard.
package ds_scoreboard_pkg;

    localparam int unsigned GPR_NUM   = 32;
    localparam int unsigned REG_AW    = 5;
    localparam int unsigned CNT_W_DEF = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage : ds_scoreboard_pkg

// File: rtl/ds_scoreboard_counter.sv
// Per-register pending-write counter: up on issue, down on retire, cleared by flush.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic zero_c,
    output logic full_c,
    output logic underflow_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign zero_c      = (cnt == '0);
    assign full_c      = (cnt == CNT_MAX);
    // A lone retire against an empty counter is an accounting error; flush discards the retire.
    assign underflow_c = dec & ~inc & zero_c & ~clr;

    // Next count: flush wins, simultaneous inc/dec cancel, saturate at both ends.
    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && !dec && !full_c) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (dec && !inc && !zero_c) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule : sb_counter

// File: rtl/ds_scoreboard.sv
// Decode-stage RAW/in-flight-write scoreboard producing ds_ready_go.
module ds_scoreboard
    import ds_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ds_valid,
    input  logic                   es_allowin,
    input  logic [REG_AW-1:0]      ds_rs,
    input  logic [REG_AW-1:0]      ds_rt,
    input  logic                   ds_rs_used,
    input  logic                   ds_rt_used,
    input  logic                   ds_gr_we,
    input  logic [REG_AW-1:0]      ds_dest,
    input  logic                   ws_rf_we,
    input  logic [REG_AW-1:0]      ws_rf_waddr,
    input  logic                   flush,
    output logic                   ds_ready_go,
    output logic [GPR_NUM-1:0]     busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   sb_err
);

    logic [GPR_NUM-1:0] zero_vec;
    logic [GPR_NUM-1:0] full_vec;
    logic [GPR_NUM-1:0] uf_vec;
    logic               raw_rs;
    logic               raw_rt;
    logic               full_hz;
    logic               fire;
    logic               issue_wr;
    logic               retire;

    // r0 is hardwired zero and never tracked.
    assign zero_vec[0] = 1'b1;
    assign full_vec[0] = 1'b0;
    assign uf_vec[0]   = 1'b0;

    assign fire     = ds_valid & ds_ready_go & es_allowin;
    assign issue_wr = fire & ds_gr_we & (ds_dest != REG_ZERO);
    assign retire   = ws_rf_we & (ws_rf_waddr != REG_ZERO);

    // One pending-write counter per architectural register r1..r31.
    for (genvar i = 1; i < GPR_NUM; i++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = issue_wr & (ds_dest == REG_AW'(i));
        assign dec = retire & (ws_rf_waddr == REG_AW'(i));
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .resetn      (resetn),
            .inc         (inc),
            .dec         (dec),
            .clr         (flush),
            .zero_c      (zero_vec[i]),
            .full_c      (full_vec[i]),
            .underflow_c (uf_vec[i])
        );
    end

    assign busy_vec = ~zero_vec;

    // Hazards from registered counters only, so a same-cycle retire never unblocks a reader.
    always_comb begin
        raw_rs      = 1'b0;
        raw_rt      = 1'b0;
        full_hz     = 1'b0;
        raw_rs      = ds_rs_used & (ds_rs != REG_ZERO) & ~zero_vec[ds_rs];
        raw_rt      = ds_rt_used & (ds_rt != REG_ZERO) & ~zero_vec[ds_rt];
        full_hz     = ds_gr_we & (ds_dest != REG_ZERO) & full_vec[ds_dest];
        ds_ready_go = ~(raw_rs | raw_rt | full_hz);
    end

    // Stall-cycle performance counter; wraps naturally, untouched by flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
        end else if (ds_valid && !ds_ready_go) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    // Sticky retire-underflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err <= 1'b0;
        end else if (|uf_vec) begin
            sb_err <= 1'b1;
        end
    end

endmodule : ds_scoreboard

// File: doc/ds_scoreboard.md
Name: ds_scoreboard

Overview:
- Register-hazard scheduler for the decode stage of the 5-stage MIPS pipeline.
- Keeps one in-flight-write counter per GPR.
  - Increments when decode issues an instruction that writes a register.
  - Decrements when writeback commits that register to the regfile.
- Drives ds_ready_go: decode holds until every source register it reads has no pending write.
- Sits beside id_stage. Its ds_ready_go output replaces the constant-1 ready in id_stage.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^CNT_W-1.
- STALL_CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous active-low reset.
- ds_valid  in  1  decode holds a valid instruction.
- es_allowin  in  1  execute stage can accept.
- ds_rs  in  5  rs field of the decode instruction.
- ds_rt  in  5  rt field of the decode instruction.
- ds_rs_used  in  1  instruction reads rs.
- ds_rt_used  in  1  instruction reads rt.
- ds_gr_we  in  1  instruction writes a GPR.
- ds_dest  in  5  destination register.
- ws_rf_we  in  1  writeback commits this cycle.
- ws_rf_waddr  in  5  writeback destination.
- flush  in  1  discard all in-flight tracking (pipeline flush).
- ds_ready_go  out  1  decode may hand off to execute.
- busy_vec  out  32  bit i set when counter[i] != 0.
- stall_cnt  out  STALL_CNT_W  cycles in which ds_valid=1 and ds_ready_go=0.
- sb_err  out  1  sticky error: a retire arrived for a register whose counter was zero.

Behaviour:
- Reset (resetn=0, asynchronous): all counters 0, busy_vec=0, stall_cnt=0, sb_err=0. ds_ready_go then evaluates to 1 while ds_valid=0.
- Register 0 is never tracked:
  - issue with ds_dest=0 does not increment;
  - retire with ws_rf_waddr=0 is ignored (no decrement, no error).
- Hazard terms (combinational from registered counters):
  - raw_rs = ds_rs_used & ds_rs!=0 & counter[ds_rs]!=0.
  - raw_rt = ds_rt_used & ds_rt!=0 & counter[ds_rt]!=0.
  - full = ds_gr_we & ds_dest!=0 & counter[ds_dest]==2^CNT_W-1.
- ds_ready_go = ~(raw_rs | raw_rt | full).
- Retire timing: a retire in the current cycle does NOT clear a hazard in that same cycle. The regfile is written at the clock edge, so a same-cycle read returns the stale value. The consumer stalls at least one cycle after the last retire.
- Issue fire = ds_valid & ds_ready_go & es_allowin. On fire with ds_gr_we & ds_dest!=0: counter[ds_dest] += 1 at the next edge.
- Retire = ws_rf_we & ws_rf_waddr!=0:
  - counter[ws_rf_waddr] -= 1 at the next edge;
  - if that counter is already 0: no change and sb_err<=1.
- Simultaneous issue and retire:
  - same register: counter unchanged;
  - different registers: both updates applied.
- flush=1: all counters <=0 at the next edge. It overrides issue and retire in the same cycle. stall_cnt and sb_err are unaffected.
- stall_cnt:
  - increments by 1 each cycle with ds_valid & ~ds_ready_go;
  - wraps modulo 2^STALL_CNT_W;
  - not affected by flush.
- busy_vec is registered-state derived: bit i = |counter[i]. Bit 0 is always 0.
- Reset asserted mid-operation clears all state immediately. In-flight retires arriving after reset release set sb_err. That is the expected and documented outcome.
- Latency:
  - issue-to-busy visible: 1 cycle;
  - retire-to-ready: ds_ready_go rises the cycle after the last retire edge.

Decomposition:
- Shared package / mycpu.h:
  - GPR count (32);
  - register-address width (5);
  - CNT_W default;
  - a named constant for the zero register.
- One natural sub-module: sb_counter — a single CNT_W up/down counter with inc, dec, clr, and zero/full flags and an underflow pulse. It is instantiated 31 times (r1..r31) by a generate loop. The top holds hazard compare, stall counter and sb_err.

Test Plan:
- Back-to-back dependency: issue addu r3 (dest 3) at cycle 0. Next instruction reads rs=3. Expect ds_ready_go=0 and busy_vec[3]=1. Retire r3 at cycle 3 gives ds_ready_go=1 at cycle 4; stall_cnt=3.
- Independent stream: dests 1,2,4 read sources 5,6 with es_allowin=1. Expect ds_ready_go=1 every cycle and stall_cnt=0.
- Same-cycle issue+retire on r7 with counter[7]=1: counter stays 1, busy_vec[7]=1. A following retire r7 clears it to 0.
- Saturation (CNT_W=2): three issues to r9 without retire. The fourth writer to r9 holds ds_ready_go=0 until one retire, then issues.
- r0 and underflow: issue dest 0 leaves busy_vec=0. Retire waddr=0 leaves sb_err=0. Retire r12 with counter 0 sets sb_err=1, which stays set.
- Flush / reset: with busy_vec=0x0000_0A08, flush=1 gives busy_vec=0 next cycle and stall_cnt held. Then resetn=0 mid-cycle clears stall_cnt and sb_err asynchronously.
